// File: rtl/qpmm_seq_ctrl.sv
// Sequencer for QPMM modular multiplies: drives RAM addressing, tracks per-address hazards,
// times the fixed-latency writeback, and runs the flush/drain handshake.
module qpmm_seq_ctrl #(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned RAM_LAT = 2,
    parameter int unsigned MUL_LAT = 16,
    parameter int unsigned CNT_W   = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_dst,
    input  logic [ADDR_W-1:0] cmd_src_a,
    input  logic [ADDR_W-1:0] cmd_src_b,
    input  logic              flush,
    output logic              flush_done,
    output logic [ADDR_W-1:0] rd_addr_a,
    output logic [ADDR_W-1:0] rd_addr_b,
    output logic              mul_in_valid,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              busy,
    output logic [CNT_W-1:0]  inflight,
    output logic [31:0]       op_count,
    output logic              mul_rstn
);

    localparam int unsigned LAT   = 1 + RAM_LAT + MUL_LAT;
    localparam int unsigned DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {StRun, StDrain, StDone, StWait} state_e;

    state_e             state_q, state_d;
    logic [DEPTH-1:0]   pend_q, pend_d;
    logic [LAT-1:0]     vld_q;
    logic [ADDR_W-1:0]  dst_q [LAT];
    logic [ADDR_W-1:0]  rd_a_q, rd_b_q;
    logic [CNT_W-1:0]   inflight_q, inflight_d;
    logic [31:0]        op_count_q;
    logic               hazard, accept, wb;

    // Checking dst against pend also guarantees set and clear never collide on one address.
    assign hazard    = pend_q[cmd_src_a] | pend_q[cmd_src_b] | pend_q[cmd_dst];
    assign cmd_ready = (state_q == StRun) & ~flush & ~hazard & ~rst;
    assign accept    = cmd_valid & cmd_ready;
    assign wb        = vld_q[LAT-1];

    assign rd_addr_a    = rd_a_q;
    assign rd_addr_b    = rd_b_q;
    assign mul_in_valid = vld_q[RAM_LAT];
    assign wr_en        = wb;
    assign wr_addr      = dst_q[LAT-1];
    assign inflight     = inflight_q;
    assign op_count     = op_count_q;
    assign flush_done   = (state_q == StDone);
    assign busy         = (inflight_q != '0) | (state_q != StRun);
    assign mul_rstn     = ~rst;

    always_comb begin
        pend_d = pend_q;
        if (wb) begin
            pend_d[dst_q[LAT-1]] = 1'b0;
        end
        if (accept) begin
            pend_d[cmd_dst] = 1'b1;
        end
    end

    always_comb begin
        inflight_d = inflight_q;
        if (accept && !wb) begin
            inflight_d = inflight_q + CNT_W'(1);
        end else if (!accept && wb) begin
            inflight_d = inflight_q - CNT_W'(1);
        end
    end

    // Uses the next-cycle count so the done pulse lands right after the last writeback.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StRun: begin
                if (flush) begin
                    state_d = (inflight_d == '0) ? StDone : StDrain;
                end
            end
            StDrain: begin
                if (inflight_d == '0) begin
                    state_d = StDone;
                end
            end
            StDone: state_d = StWait;
            StWait: begin
                if (!flush) begin
                    state_d = StRun;
                end
            end
            default: state_d = StRun;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StRun;
            pend_q     <= '0;
            vld_q      <= '0;
            rd_a_q     <= '0;
            rd_b_q     <= '0;
            inflight_q <= '0;
            op_count_q <= '0;
            for (int unsigned i = 0; i < LAT; i++) begin
                dst_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            pend_q     <= pend_d;
            vld_q      <= {vld_q[LAT-2:0], accept};
            inflight_q <= inflight_d;
            dst_q[0]   <= cmd_dst;
            for (int unsigned i = 1; i < LAT; i++) begin
                dst_q[i] <= dst_q[i-1];
            end
            if (accept) begin
                rd_a_q <= cmd_src_a;
                rd_b_q <= cmd_src_b;
            end
            if (wb) begin
                op_count_q <= op_count_q + 32'd1;
            end
        end
    end

endmodule
